// File: rtl/cmd_issuer_pkg.sv
// Shared definitions for the host-side command issuer: FIFO word width, default timeout word
// and the command target-field decode.
package cmd_issuer_pkg;

    localparam int unsigned WORD_W = 32;
    localparam logic [WORD_W-1:0] DEFAULT_TIMEOUT_WORD = 32'hDEAD_0000;

    // Command word layout: target selector in the top byte, payload below.
    typedef struct packed {
        logic [7:0]  target;
        logic [23:0] payload;
    } cmd_word_t;

    localparam logic [7:0] C_TARGET_CTRL = 8'h00;
    localparam logic [7:0] C_TARGET_REG  = 8'h01;
    localparam logic [7:0] C_TARGET_MEM  = 8'h02;
    localparam logic [7:0] C_TARGET_DMA  = 8'h03;

    function automatic logic [7:0] cmd_target(input logic [WORD_W-1:0] cmd);
        cmd_word_t w;
        w = cmd_word_t'(cmd);
        return w.target;
    endfunction

endpackage

// File: rtl/cmd_issuer_timer.sv
// Response-wait timer: cleared when a command is written, counts while enabled and flags the
// last cycle of the timeout window. Used only when CMD_ISSUER_TIMEOUT_EN is defined.
module cmd_issuer_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] Last = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != Last)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == Last);

endmodule

// File: rtl/cmd_issuer.sv
// Host-side initiator for the cmd/rsp FIFO pair: one command outstanding, stale responses drained.
// Define CMD_ISSUER_TIMEOUT_EN to enable the response timeout path (timer, error word, counter).
module cmd_issuer
    import cmd_issuer_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter int unsigned       CNT_W          = 16,
    parameter logic [WORD_W-1:0] TIMEOUT_WORD   = DEFAULT_TIMEOUT_WORD
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] host_cmd_data,
    input  logic              host_cmd_valid,
    output logic              host_cmd_ready,
    output logic [WORD_W-1:0] host_rsp_data,
    output logic              host_rsp_err,
    output logic              host_rsp_valid,
    input  logic              host_rsp_ready,
    output logic [WORD_W-1:0] cmd_wrdata,
    output logic              cmd_wrreq,
    input  logic              cmd_wr_waitreq,
    input  logic [WORD_W-1:0] rsp_rddata,
    output logic              rsp_rdreq,
    input  logic              rsp_rd_waitreq,
    output logic [CNT_W-1:0]  cmd_cnt,
    output logic [CNT_W-1:0]  timeout_cnt,
    output logic [CNT_W-1:0]  stale_cnt
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_WR_CMD   = 3'd1;
    localparam logic [2:0] S_WAIT_RSP = 3'd2;
    localparam logic [2:0] S_RD_RSP   = 3'd3;
    localparam logic [2:0] S_HOST_RSP = 3'd4;
    localparam logic [2:0] S_DRAIN    = 3'd5;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]        state_q, state_d;
    logic [WORD_W-1:0] cmd_data_q, cmd_data_d;
    logic [WORD_W-1:0] rsp_data_q, rsp_data_d;
    logic [CNT_W-1:0]  cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]  stale_cnt_q, stale_cnt_d;

`ifdef CMD_ISSUER_TIMEOUT_EN
    logic             rsp_err_q, rsp_err_d;
    logic [CNT_W-1:0] timeout_cnt_q, timeout_cnt_d;
    logic             timer_clear, timer_en, timer_expired;

    assign timer_clear = (state_q == S_WR_CMD) && !cmd_wr_waitreq;
    assign timer_en    = (state_q == S_WAIT_RSP);

    cmd_issuer_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (timer_clear),
        .enable_i (timer_en),
        .expired_o(timer_expired)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cmd_data_d  = cmd_data_q;
        rsp_data_d  = rsp_data_q;
        cmd_cnt_d   = cmd_cnt_q;
        stale_cnt_d = stale_cnt_q;
`ifdef CMD_ISSUER_TIMEOUT_EN
        rsp_err_d     = rsp_err_q;
        timeout_cnt_d = timeout_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // A word sitting in the rsp FIFO here is stale and must go before a new command.
                if (!rsp_rd_waitreq) begin
                    state_d = S_DRAIN;
                end else if (host_cmd_valid) begin
                    cmd_data_d = host_cmd_data;
                    state_d    = S_WR_CMD;
                end
            end
            S_DRAIN: begin
                stale_cnt_d = sat_inc(stale_cnt_q);
                state_d     = S_IDLE;
            end
            S_WR_CMD: begin
                if (!cmd_wr_waitreq) begin
                    cmd_cnt_d = sat_inc(cmd_cnt_q);
                    state_d   = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                if (!rsp_rd_waitreq) begin
                    state_d = S_RD_RSP;
`ifdef CMD_ISSUER_TIMEOUT_EN
                end else if (timer_expired) begin
                    rsp_data_d    = TIMEOUT_WORD;
                    rsp_err_d     = 1'b1;
                    timeout_cnt_d = sat_inc(timeout_cnt_q);
                    state_d       = S_HOST_RSP;
`endif
                end
            end
            S_RD_RSP: begin
                rsp_data_d = rsp_rddata;
`ifdef CMD_ISSUER_TIMEOUT_EN
                rsp_err_d  = 1'b0;
`endif
                state_d    = S_HOST_RSP;
            end
            S_HOST_RSP: begin
                if (host_rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cmd_data_q  <= '0;
            rsp_data_q  <= '0;
            cmd_cnt_q   <= '0;
            stale_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cmd_data_q  <= cmd_data_d;
            rsp_data_q  <= rsp_data_d;
            cmd_cnt_q   <= cmd_cnt_d;
            stale_cnt_q <= stale_cnt_d;
        end
    end

`ifdef CMD_ISSUER_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err_q     <= 1'b0;
            timeout_cnt_q <= '0;
        end else begin
            rsp_err_q     <= rsp_err_d;
            timeout_cnt_q <= timeout_cnt_d;
        end
    end

    assign host_rsp_err = rsp_err_q;
    assign timeout_cnt  = timeout_cnt_q;
`else
    assign host_rsp_err = 1'b0;
    assign timeout_cnt  = '0;
`endif

    assign host_cmd_ready = (state_q == S_IDLE) && rsp_rd_waitreq;
    assign cmd_wrreq      = (state_q == S_WR_CMD) && !cmd_wr_waitreq;
    assign rsp_rdreq      = (state_q == S_RD_RSP) || (state_q == S_DRAIN);
    assign host_rsp_valid = (state_q == S_HOST_RSP);
    assign host_rsp_data  = rsp_data_q;
    assign cmd_wrdata     = cmd_data_q;
    assign cmd_cnt        = cmd_cnt_q;
    assign stale_cnt      = stale_cnt_q;

endmodule
